mem_port_arbiter: RTL and testbench

Shares the single-ported unified memory between the instruction-fetch stage (IF) and the data-memory stage (DM) of the pipelined RISC-V core. Data accesses win by default, and a starvation limit guarantees fetch progress. The block generates per-requester ready pulses that the pipeline uses as stall releases. It also keeps saturating stall-cycle counters so branch-predictor experiments can attribute lost cycles to memory contention.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between instruction fetch (IF) and the
// data-memory stage (DM). One access is outstanding at a time. Data accesses
// win by default. A starvation counter forces an IF grant after STARVE_LIMIT
// consecutive DM grants that were issued while IF was waiting.
//
// Handshake: a requester raises *_req and holds it, along with stable
// address, data and enables, until it sees its *_ready pulse. *_ready is
// high for exactly one cycle. *_rdata is meaningful only in that cycle.
// Nothing is issued in the ready cycle, because the completing requester is
// still holding req then.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   if_req/if_addr    fetch request and byte address
//   if_rdata/if_ready fetch data and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be   data request (load or store)
//   dm_rdata/dm_ready data result and one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be  memory access strobe and fields
//   mem_rdata         memory read data, MEM_LATENCY cycles after issue
//   if_stall_cnt      saturating count of cycles with if_req=1, if_ready=0
//   dm_stall_cnt      saturating count of cycles with dm_req=1, dm_ready=0
//   dbg_busy          1 while an access is outstanding (FSM state BUSY)
//   dbg_starve_cnt    current starvation counter
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  output logic [31:0] if_stall_cnt,
  output logic [31:0] dm_stall_cnt,
  output logic        dbg_busy,
  output logic [3:0]  dbg_starve_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] LAT   = 4'(MEM_LATENCY);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic       owner_dm;
  logic [3:0] wait_cnt;
  logic [3:0] starve_cnt;
  logic       grant_if, grant_dm, done;

  // Next state and grant decision. Grants are gated by reset so that nothing
  // is issued while reset is held, even though IDLE grants combinationally.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (reset) begin
          if (dm_req && !(if_req && starve_cnt == LIMIT)) grant_dm = 1'b1;
          else if (if_req)                                 grant_if = 1'b1;
        end
        if (grant_dm || grant_if) state_nxt = BUSY;
      end
      BUSY: begin
        // The wait count would reach zero with this cycle's decrement.
        done = (wait_cnt == 4'd1);
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = grant_if | grant_dm;
    mem_we    = grant_dm & dm_we;
    mem_addr  = grant_dm ? dm_addr : if_addr;
    mem_wdata = dm_wdata;
    mem_be    = grant_dm ? dm_be : 4'hF;
    if_ready  = done & ~owner_dm;
    dm_ready  = done &  owner_dm;
    if_rdata  = mem_rdata;
    dm_rdata  = mem_rdata;
    dbg_busy       = (state == BUSY);
    dbg_starve_cnt = starve_cnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner_dm   <= 1'b0;
      wait_cnt   <= 4'd0;
      starve_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (mem_en) begin
        owner_dm <= grant_dm;
        // Stores complete the cycle after issue; reads wait for the memory.
        wait_cnt <= (grant_dm && dm_we) ? 4'd1 : LAT;
      end else if (state == BUSY) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (grant_if) begin
        starve_cnt <= 4'd0;
      end else if (grant_dm) begin
        if (!if_req)                  starve_cnt <= 4'd0;
        else if (starve_cnt != 4'hF)  starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_stall_cnt <= 32'd0;
      dm_stall_cnt <= 32'd0;
    end else begin
      if (if_req && !if_ready && if_stall_cnt != 32'hFFFF_FFFF)
        if_stall_cnt <= if_stall_cnt + 32'd1;
      if (dm_req && !dm_ready && dm_stall_cnt != 32'hFFFF_FFFF)
        dm_stall_cnt <= dm_stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed vector table plus hand-written sequences (reset, starvation,
// mid-access reset), followed by randomized traffic checked against a
// cycle-stamp reference model. The memory model returns address ^ A5A5_A5A5
// MEM_LATENCY cycles after issue.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int LAT   = 2;
  localparam int LIMIT = 2;
  localparam logic [31:0] MAGIC = 32'hA5A5_A5A5;

  // Clock / reset and DUT signals
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic [31:0] if_stall_cnt;
  logic [31:0] dm_stall_cnt;
  logic        dbg_busy;
  logic [3:0]  dbg_starve_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata),
    .if_stall_cnt(if_stall_cnt), .dm_stall_cnt(dm_stall_cnt),
    .dbg_busy(dbg_busy), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // Memory model: two-stage address pipe (LAT = 2).
  logic [31:0] pipe0 = 32'd0;
  logic [31:0] pipe1 = 32'd0;
  always @(posedge clk) begin
    pipe0 <= mem_addr;
    pipe1 <= pipe0;
  end
  assign mem_rdata = pipe1 ^ MAGIC;

  // Scoreboard
  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after posedge, outputs are
  // sampled at negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'd0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0; dm_be = 4'hF;
  endtask

  task automatic do_reset();
    tick();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Directed vector table
  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_ifr;
    logic        e_dmr;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic ifq, logic [31:0] ifa, logic dmq, logic dwe,
                              logic [31:0] dma, logic [31:0] dwd, logic [3:0] dbe,
                              logic een, logic ewe, logic [31:0] ea, logic [3:0] ebe,
                              logic eifr, logic edmr, logic [31:0] erd);
    vec_t v;
    v.if_req = ifq; v.if_addr = ifa; v.dm_req = dmq; v.dm_we = dwe;
    v.dm_addr = dma; v.dm_wdata = dwd; v.dm_be = dbe;
    v.e_en = een; v.e_we = ewe; v.e_addr = ea; v.e_be = ebe;
    v.e_ifr = eifr; v.e_dmr = edmr; v.e_rdata = erd;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // ---------------- reset with a pending fetch ----------------
    idle_inputs();
    reset  = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      sample();
      chk("rst mem_en", 32'(mem_en), 32'd0);
      chk("rst if_ready", 32'(if_ready), 32'd0);
      chk("rst dm_ready", 32'(dm_ready), 32'd0);
      chk("rst if_stall", if_stall_cnt, 32'd0);
      chk("rst dm_stall", dm_stall_cnt, 32'd0);
    end
    tick();
    reset = 1'b1;
    sample();
    chk("rel issue mem_en", 32'(mem_en), 32'd1);
    chk("rel issue addr", mem_addr, 32'h0);
    tick(); sample();
    chk("rel wait if_ready", 32'(if_ready), 32'd0);
    tick(); sample();
    chk("rel if_ready", 32'(if_ready), 32'd1);
    chk("rel if_rdata", if_rdata, 32'hA5A5_A5A5);

    // ---------------- table: fetch stream, contention, store ----------------
    tbl[0]  = mk(1, 32'h0,  0, 0, 32'h0,   32'h0, 4'hF, 1, 0, 32'h0,   4'hF, 0, 0, 32'h0);
    tbl[1]  = mk(1, 32'h0,  0, 0, 32'h0,   32'h0, 4'hF, 0, 0, 32'h0,   4'hF, 0, 0, 32'h0);
    tbl[2]  = mk(1, 32'h0,  0, 0, 32'h0,   32'h0, 4'hF, 0, 0, 32'h0,   4'hF, 1, 0, 32'hA5A5_A5A5);
    tbl[3]  = mk(1, 32'h4,  0, 0, 32'h0,   32'h0, 4'hF, 1, 0, 32'h4,   4'hF, 0, 0, 32'h0);
    tbl[4]  = mk(1, 32'h4,  0, 0, 32'h0,   32'h0, 4'hF, 0, 0, 32'h0,   4'hF, 0, 0, 32'h0);
    tbl[5]  = mk(1, 32'h4,  0, 0, 32'h0,   32'h0, 4'hF, 0, 0, 32'h0,   4'hF, 1, 0, 32'hA5A5_A5A1);
    tbl[6]  = mk(1, 32'h8,  0, 0, 32'h0,   32'h0, 4'hF, 1, 0, 32'h8,   4'hF, 0, 0, 32'h0);
    tbl[7]  = mk(1, 32'h8,  0, 0, 32'h0,   32'h0, 4'hF, 0, 0, 32'h0,   4'hF, 0, 0, 32'h0);
    tbl[8]  = mk(1, 32'h8,  0, 0, 32'h0,   32'h0, 4'hF, 0, 0, 32'h0,   4'hF, 1, 0, 32'hA5A5_A5AD);
    tbl[9]  = mk(0, 32'h0,  0, 0, 32'h0,   32'h0, 4'hF, 0, 0, 32'h0,   4'hF, 0, 0, 32'h0);
    tbl[10] = mk(1, 32'h40, 1, 0, 32'h100, 32'h0, 4'hF, 1, 0, 32'h100, 4'hF, 0, 0, 32'h0);
    tbl[11] = mk(1, 32'h40, 1, 0, 32'h100, 32'h0, 4'hF, 0, 0, 32'h0,   4'hF, 0, 0, 32'h0);
    tbl[12] = mk(1, 32'h40, 1, 0, 32'h100, 32'h0, 4'hF, 0, 0, 32'h0,   4'hF, 0, 1, 32'hA5A5_A4A5);
    tbl[13] = mk(1, 32'h40, 0, 0, 32'h0,   32'h0, 4'hF, 1, 0, 32'h40,  4'hF, 0, 0, 32'h0);
    tbl[14] = mk(1, 32'h40, 0, 0, 32'h0,   32'h0, 4'hF, 0, 0, 32'h0,   4'hF, 0, 0, 32'h0);
    tbl[15] = mk(1, 32'h40, 0, 0, 32'h0,   32'h0, 4'hF, 0, 0, 32'h0,   4'hF, 1, 0, 32'hA5A5_A5E5);
    tbl[16] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0, 4'hF, 0, 0, 32'h0,   4'hF, 0, 0, 32'h0);
    tbl[17] = mk(0, 32'h0,  1, 1, 32'h200, 32'h1234_5678, 4'h3, 1, 1, 32'h200, 4'h3, 0, 0, 32'h0);
    tbl[18] = mk(0, 32'h0,  1, 1, 32'h200, 32'h1234_5678, 4'h3, 0, 0, 32'h0, 4'hF, 0, 1, 32'h0);
    tbl[19] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0, 4'hF, 0, 0, 32'h0,   4'hF, 0, 0, 32'h0);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
      dm_req = tbl[i].dm_req; dm_we = tbl[i].dm_we; dm_addr = tbl[i].dm_addr;
      dm_wdata = tbl[i].dm_wdata; dm_be = tbl[i].dm_be;
      sample();
      chk($sformatf("row%0d mem_en", i), 32'(mem_en), 32'(tbl[i].e_en));
      chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(tbl[i].e_we));
      chk($sformatf("row%0d if_ready", i), 32'(if_ready), 32'(tbl[i].e_ifr));
      chk($sformatf("row%0d dm_ready", i), 32'(dm_ready), 32'(tbl[i].e_dmr));
      if (tbl[i].e_en) begin
        chk($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].e_addr);
        chk($sformatf("row%0d mem_be", i), 32'(mem_be), 32'(tbl[i].e_be));
      end
      if (tbl[i].e_we) chk($sformatf("row%0d mem_wdata", i), mem_wdata, tbl[i].dm_wdata);
      if (tbl[i].e_ifr) chk($sformatf("row%0d if_rdata", i), if_rdata, tbl[i].e_rdata);
      if (tbl[i].e_dmr && !tbl[i].dm_we)
        chk($sformatf("row%0d dm_rdata", i), dm_rdata, tbl[i].e_rdata);
      if (i == 8) chk("if_stall after 3 fetches", if_stall_cnt, 32'd6);
      if (i == 19) begin
        chk("if_stall end of table", if_stall_cnt, 32'd11);
        chk("dm_stall end of table", dm_stall_cnt, 32'd3);
      end
    end

    // ---------------- starvation: grant order DM DM IF DM DM IF ----------------
    do_reset();
    exp_q.delete();
    exp_q.push_back(32'h300); exp_q.push_back(32'h300); exp_q.push_back(32'h80);
    exp_q.push_back(32'h300); exp_q.push_back(32'h300); exp_q.push_back(32'h80);
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      tick();
      if_req = 1'b1; if_addr = 32'h80;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_be = 4'hF;
      sample();
      chk("starve bound", 32'(dbg_starve_cnt <= 4'(LIMIT)), 32'd1);
      if (mem_en) chk("grant order", mem_addr, exp_q.pop_front());
    end
    chk("grants outstanding", 32'(exp_q.size()), 32'd0);

    // ---------------- reset in the middle of a load ----------------
    do_reset();
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400; dm_be = 4'hF;
    sample();
    chk("mar issue", 32'(mem_en), 32'd1);
    tick();
    reset = 1'b0;
    sample();
    chk("mar busy cleared", 32'(dbg_busy), 32'd0);
    chk("mar mem_en in reset", 32'(mem_en), 32'd0);
    chk("mar dm_ready in reset 1", 32'(dm_ready), 32'd0);
    tick(); sample();
    chk("mar dm_ready in reset 2", 32'(dm_ready), 32'd0);
    tick();
    reset = 1'b1;
    sample();
    chk("mar reissue en", 32'(mem_en), 32'd1);
    chk("mar reissue addr", mem_addr, 32'h400);
    chk("mar reissue dm_ready", 32'(dm_ready), 32'd0);
    tick(); sample();
    chk("mar wait dm_ready", 32'(dm_ready), 32'd0);
    tick(); sample();
    chk("mar dm_ready", 32'(dm_ready), 32'd1);
    chk("mar dm_rdata", dm_rdata, 32'hA5A5_A1A5);

    // ---------------- randomized traffic vs cycle-stamp model ----------------
    do_reset();
    exp_q.delete();
    begin
      int   ready_at = -1;
      bit   m_owner_dm = 1'b0;
      bit   m_store = 1'b0;
      int   m_starve = 0;
      int   m_if_st = 0;
      int   m_dm_st = 0;
      bit   if_pend = 1'b0, dm_pend = 1'b0;
      bit   prev_ifr = 1'b0, prev_dmr = 1'b0;
      bit   e_en, e_we, e_ifr, e_dmr, granted;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      for (int c = 0; c < 1500; c++) begin
        tick();
        if (if_pend && prev_ifr) if_pend = 1'b0;
        if (dm_pend && prev_dmr) dm_pend = 1'b0;
        if (!if_pend && $urandom_range(0, 9) < 5) begin
          if_pend = 1'b1;
          if_addr = $urandom() & 32'hFFFF_FFFC;
        end
        if (!dm_pend && $urandom_range(0, 9) < 5) begin
          dm_pend  = 1'b1;
          dm_we    = 1'($urandom_range(0, 1));
          dm_addr  = $urandom() & 32'hFFFF_FFFC;
          dm_wdata = $urandom();
          dm_be    = dm_we ? 4'($urandom_range(1, 15)) : 4'hF;
        end
        if_req = if_pend;
        dm_req = dm_pend;

        e_en = 0; e_we = 0; e_ifr = 0; e_dmr = 0; granted = 0;
        e_addr = 32'h0; e_be = 4'h0;
        if (c == ready_at) begin
          if (m_owner_dm) e_dmr = 1'b1;
          else            e_ifr = 1'b1;
        end else if (c > ready_at && (if_req || dm_req)) begin
          granted    = 1'b1;
          m_owner_dm = dm_req && !(if_req && m_starve == LIMIT);
          m_store    = m_owner_dm && dm_we;
          e_en   = 1'b1;
          e_we   = m_store;
          e_addr = m_owner_dm ? dm_addr : if_addr;
          e_be   = m_owner_dm ? dm_be : 4'hF;
          ready_at = c + (m_store ? 1 : LAT);
          if (!m_store) exp_q.push_back(e_addr ^ MAGIC);
        end

        sample();
        chk("rnd starve_cnt", 32'(dbg_starve_cnt), 32'(m_starve));
        chk("rnd mem_en", 32'(mem_en), 32'(e_en));
        chk("rnd mem_we", 32'(mem_we), 32'(e_we));
        chk("rnd if_ready", 32'(if_ready), 32'(e_ifr));
        chk("rnd dm_ready", 32'(dm_ready), 32'(e_dmr));
        chk("rnd if_stall", if_stall_cnt, 32'(m_if_st));
        chk("rnd dm_stall", dm_stall_cnt, 32'(m_dm_st));
        if (e_en) begin
          chk("rnd mem_addr", mem_addr, e_addr);
          chk("rnd mem_be", 32'(mem_be), 32'(e_be));
        end
        if (e_we) chk("rnd mem_wdata", mem_wdata, dm_wdata);
        if ((e_ifr || e_dmr) && !m_store) begin
          if (exp_q.size() == 0) begin
            chk("rnd rdata queue", 32'd0, 32'd1);
          end else if (e_ifr) begin
            chk("rnd if_rdata", if_rdata, exp_q.pop_front());
          end else begin
            chk("rnd dm_rdata", dm_rdata, exp_q.pop_front());
          end
        end

        if (if_req && !e_ifr) m_if_st++;
        if (dm_req && !e_dmr) m_dm_st++;
        if (granted) m_starve = (m_owner_dm && if_req) ? m_starve + 1 : 0;
        prev_ifr = e_ifr;
        prev_dmr = e_dmr;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
